// File: rtl/pet_crtc_timing.sv
// CRTC-style video timing generator: hsync/vsync/de plus character memory
// address (ma) and scanline (ra), advancing once per character clock enable.
module pet_crtc_timing #(
  parameter int MA_W = 14,
  parameter int HC_W = 8,
  parameter int VR_W = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ce,
  input  logic [HC_W-1:0] h_total,
  input  logic [HC_W-1:0] h_disp,
  input  logic [HC_W-1:0] h_sync_pos,
  input  logic [3:0]      h_sync_w,
  input  logic [VR_W-1:0] v_total,
  input  logic [VR_W-1:0] v_disp,
  input  logic [VR_W-1:0] v_sync_pos,
  input  logic [3:0]      v_sync_w,
  input  logic [3:0]      max_ra,
  input  logic [MA_W-1:0] start_addr,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [MA_W-1:0] ma,
  output logic [3:0]      ra,
  output logic            frame_start
);

  // Raster counters
  logic [HC_W-1:0] hc;
  logic [3:0]      sl;
  logic [VR_W-1:0] row;
  logic [MA_W-1:0] ma_row;

  // Sync width counters: *_cnt holds the remaining units after the current
  // one, *_act marks a pulse in progress.
  logic [3:0]      hs_cnt;
  logic [3:0]      vs_cnt;
  logic            hs_act;
  logic            vs_act;

  // Configuration shadows, only refreshed at the frame boundary
  logic [HC_W-1:0] sh_h_total;
  logic [HC_W-1:0] sh_h_disp;
  logic [HC_W-1:0] sh_h_sync_pos;
  logic [3:0]      sh_h_sync_w;
  logic [VR_W-1:0] sh_v_total;
  logic [VR_W-1:0] sh_v_disp;
  logic [VR_W-1:0] sh_v_sync_pos;
  logic [3:0]      sh_v_sync_w;
  logic [3:0]      sh_max_ra;
  logic [MA_W-1:0] sh_start_addr;

  logic            line_end;
  logic            row_end;
  logic            frame_end;
  logic            hs_start;
  logic            vs_start;
  logic            hs_on;
  logic            vs_on;
  logic [3:0]      hs_base;
  logic [3:0]      vs_base;
  logic            de_next;
  logic [MA_W-1:0] ma_next;

  assign line_end  = (hc == sh_h_total);
  assign row_end   = line_end && (sl == sh_max_ra);
  assign frame_end = row_end && (row == sh_v_total);

  // A width of 0 wraps to 15 remaining units, i.e. a 16-unit pulse.
  assign hs_start = (hc == sh_h_sync_pos);
  assign vs_start = (hc == '0) && (sl == 4'd0) && (row == sh_v_sync_pos);
  assign hs_on    = hs_start || hs_act;
  assign vs_on    = vs_start || vs_act;
  assign hs_base  = hs_start ? (sh_h_sync_w - 4'd1) : hs_cnt;
  assign vs_base  = vs_start ? (sh_v_sync_w - 4'd1) : vs_cnt;

  assign de_next = (hc < sh_h_disp) && (row < sh_v_disp);
  assign ma_next = ma_row + MA_W'(hc);

  // NOTE: reset is synchronous and overrides ce; every state element and
  // output uses non-blocking assignment so the outputs see the counters'
  // pre-increment values of the same ce.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hc            <= '0;
      sl            <= 4'd0;
      row           <= '0;
      ma_row        <= start_addr;
      hs_cnt        <= 4'd0;
      vs_cnt        <= 4'd0;
      hs_act        <= 1'b0;
      vs_act        <= 1'b0;
      sh_h_total    <= h_total;
      sh_h_disp     <= h_disp;
      sh_h_sync_pos <= h_sync_pos;
      sh_h_sync_w   <= h_sync_w;
      sh_v_total    <= v_total;
      sh_v_disp     <= v_disp;
      sh_v_sync_pos <= v_sync_pos;
      sh_v_sync_w   <= v_sync_w;
      sh_max_ra     <= max_ra;
      sh_start_addr <= start_addr;
      hsync         <= 1'b0;
      vsync         <= 1'b0;
      de            <= 1'b0;
      ma            <= '0;
      ra            <= 4'd0;
      frame_start   <= 1'b0;
    end else if (ce) begin
      // Registered outputs from the current (pre-increment) counter state
      hsync       <= hs_on;
      vsync       <= vs_on;
      de          <= de_next;
      ma          <= ma_next;
      ra          <= sl;
      frame_start <= (hc == '0) && (sl == 4'd0) && (row == '0);

      // Horizontal
      if (line_end) hc <= '0;
      else          hc <= hc + 1'b1;

      // Vertical
      if (line_end) begin
        if (row_end) begin
          sl <= 4'd0;
          if (frame_end) begin
            row    <= '0;
            ma_row <= sh_start_addr;
          end else begin
            row    <= row + 1'b1;
            ma_row <= ma_row + MA_W'(sh_h_disp);
          end
        end else begin
          sl <= sl + 4'd1;
        end
      end

      // hsync counts characters; a fresh start reloads the width
      if (hs_on) begin
        if (hs_base == 4'd0) begin
          hs_act <= 1'b0;
        end else begin
          hs_act <= 1'b1;
          hs_cnt <= hs_base - 4'd1;
        end
      end

      // vsync counts scanlines, stepping only at line_end
      if (vs_on) begin
        if (!line_end) begin
          vs_act <= 1'b1;
          vs_cnt <= vs_base;
        end else if (vs_base == 4'd0) begin
          vs_act <= 1'b0;
        end else begin
          vs_act <= 1'b1;
          vs_cnt <= vs_base - 4'd1;
        end
      end

      if (frame_end) begin
        sh_h_total    <= h_total;
        sh_h_disp     <= h_disp;
        sh_h_sync_pos <= h_sync_pos;
        sh_h_sync_w   <= h_sync_w;
        sh_v_total    <= v_total;
        sh_v_disp     <= v_disp;
        sh_v_sync_pos <= v_sync_pos;
        sh_v_sync_w   <= v_sync_w;
        sh_max_ra     <= max_ra;
        sh_start_addr <= start_addr;
      end
    end
  end

endmodule

// File: tb/tb_pet_crtc_timing.sv
// Directed bench for pet_crtc_timing: PET 40-column geometry, shadow reload,
// sync wrap/width-zero cases, ce gating, mid-frame reset, degenerate geometry.
module tb_pet_crtc_timing;

  localparam int MA_W = 14;
  localparam int HC_W = 8;
  localparam int VR_W = 7;
  localparam int PET_FRAME = 64 * 264;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            ce = 1'b1;
  logic [HC_W-1:0] h_total, h_disp, h_sync_pos;
  logic [3:0]      h_sync_w, v_sync_w, max_ra;
  logic [VR_W-1:0] v_total, v_disp, v_sync_pos;
  logic [MA_W-1:0] start_addr;
  logic            hsync, vsync, de, frame_start;
  logic [MA_W-1:0] ma;
  logic [3:0]      ra;

  int errors = 0;
  int checks = 0;

  pet_crtc_timing #(.MA_W(MA_W), .HC_W(HC_W), .VR_W(VR_W)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .h_total(h_total), .h_disp(h_disp), .h_sync_pos(h_sync_pos), .h_sync_w(h_sync_w),
    .v_total(v_total), .v_disp(v_disp), .v_sync_pos(v_sync_pos), .v_sync_w(v_sync_w),
    .max_ra(max_ra), .start_addr(start_addr),
    .hsync(hsync), .vsync(vsync), .de(de), .ma(ma), .ra(ra), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ht, input int hd, input int hsp, input int hsw,
                         input int vt, input int vd, input int vsp, input int vsw,
                         input int mra, input int sa);
    h_total    = HC_W'(ht);
    h_disp     = HC_W'(hd);
    h_sync_pos = HC_W'(hsp);
    h_sync_w   = 4'(hsw);
    v_total    = VR_W'(vt);
    v_disp     = VR_W'(vd);
    v_sync_pos = VR_W'(vsp);
    v_sync_w   = 4'(vsw);
    max_ra     = 4'(mra);
    start_addr = MA_W'(sa);
  endtask

  // One reset edge with ce high; the next tick() samples output for hc=0.
  task automatic do_reset();
    ce = 1'b1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int de_cnt, vs_cnt, first_vs, period, hs_cnt, last_fs, prev_fs, idle_changes, wait_n;
    logic [31:0] prev_out;

    // ---- Reset state and PET 40-column frame ----
    set_cfg(63, 40, 50, 4, 32, 25, 28, 4, 7, 0);
    ce = 1'b1;
    reset_n = 1'b0;
    tick();
    check("reset_outputs", 32'({hsync, vsync, de, ma, ra, frame_start}), 32'd0);
    reset_n = 1'b1;

    de_cnt = 0; vs_cnt = 0; first_vs = -1; period = -1; hs_cnt = 0;
    for (int k = 0; k < PET_FRAME + 600; k++) begin
      tick();
      if (k == 100 * 64) h_disp = 8'd80;
      if (k > 0 && frame_start && period < 0) period = k;
      if (k < PET_FRAME) begin
        if (de) de_cnt++;
        if (vsync) vs_cnt++;
        if (vsync && first_vs < 0) first_vs = k;
      end
      if (k < 64 && hsync) hs_cnt++;
      case (k)
        0:                  check("pet_fs_first", 32'(frame_start), 32'd1);
        39:                 check("pet_ma_hc39", 32'(ma), 32'h027);
        40:                 check("pet_de_hc40", 32'(de), 32'd0);
        49:                 check("pet_hs_hc49", 32'(hsync), 32'd0);
        50:                 check("pet_hs_hc50", 32'(hsync), 32'd1);
        53:                 check("pet_hs_hc53", 32'(hsync), 32'd1);
        54:                 check("pet_hs_hc54", 32'(hsync), 32'd0);
        3 * 64 + 5:         check("pet_ra_line3", 32'(ra), 32'd3);
        7 * 64:             check("pet_ra_line7", 32'(ra), 32'd7);
        8 * 64:             begin
                              check("pet_ma_row1", 32'(ma), 32'h028);
                              check("pet_ra_line8", 32'(ra), 32'd0);
                            end
        101 * 64 + 40:      check("shadow_de_hold", 32'(de), 32'd0);
        24 * 512:           check("pet_ma_row24", 32'(ma), 32'h3C0);
        25 * 512:           check("pet_de_row25", 32'(de), 32'd0);
        PET_FRAME:          check("pet_ma_frame2", 32'(ma), 32'h000);
        PET_FRAME + 45:     check("shadow_de_wide", 32'(de), 32'd1);
        PET_FRAME + 512:    check("shadow_ma_row1", 32'(ma), 32'h050);
        default: ;
      endcase
    end
    check("pet_frame_period", 32'(period), 32'(PET_FRAME));
    check("pet_de_count", 32'(de_cnt), 32'd8000);
    check("pet_vs_count", 32'(vs_cnt), 32'd256);
    check("pet_vs_first", 32'(first_vs), 32'(224 * 64));
    check("pet_hs_count", 32'(hs_cnt), 32'd4);

    // ---- hsync wrapping across line_end ----
    set_cfg(63, 40, 62, 4, 32, 25, 28, 4, 7, 0);
    do_reset();
    for (int k = 0; k < 70; k++) begin
      tick();
      case (k)
        61: check("hwrap_61", 32'(hsync), 32'd0);
        62: check("hwrap_62", 32'(hsync), 32'd1);
        63: check("hwrap_63", 32'(hsync), 32'd1);
        64: check("hwrap_0",  32'(hsync), 32'd1);
        65: check("hwrap_1",  32'(hsync), 32'd1);
        66: check("hwrap_2",  32'(hsync), 32'd0);
        default: ;
      endcase
    end

    // ---- hsync width 0 means 16 ----
    set_cfg(63, 40, 10, 0, 32, 25, 28, 4, 7, 0);
    do_reset();
    hs_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (hsync) hs_cnt++;
      if (k == 25) check("hw0_hc25", 32'(hsync), 32'd1);
      if (k == 26) check("hw0_hc26", 32'(hsync), 32'd0);
    end
    check("hw0_count", 32'(hs_cnt), 32'd16);

    // ---- v_sync_pos beyond v_total: vsync never asserts ----
    set_cfg(7, 4, 2, 1, 3, 2, 40, 4, 1, 0);
    do_reset();
    vs_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (vsync) vs_cnt++;
      if (k == 64) check("vnever_fs64", 32'(frame_start), 32'd1);
    end
    check("vnever_count", 32'(vs_cnt), 32'd0);

    // ---- ce every 3rd clk: frame of 48 ce = 144 clk ----
    set_cfg(7, 4, 2, 1, 2, 2, 1, 1, 1, 0);
    do_reset();
    last_fs = -1; period = -1; prev_fs = 0; idle_changes = 0; prev_out = '0;
    for (int c = 0; c < 160; c++) begin
      ce = (c % 3 == 0);
      tick();
      if (!ce && 32'({hsync, vsync, de, ma, ra, frame_start}) != prev_out) idle_changes++;
      prev_out = 32'({hsync, vsync, de, ma, ra, frame_start});
      if (frame_start && prev_fs == 0) begin
        if (last_fs >= 0 && period < 0) period = c - last_fs;
        last_fs = c;
      end
      prev_fs = int'(frame_start);
    end
    check("gate_idle_changes", 32'(idle_changes), 32'd0);
    check("gate_period", 32'(period), 32'd144);
    ce = 1'b1;

    // ---- reset mid-vsync cuts the pulse and restarts at the origin ----
    set_cfg(7, 4, 2, 1, 3, 2, 1, 0, 1, 'h100);
    do_reset();
    wait_n = 0;
    do begin
      tick();
      wait_n++;
    end while (!vsync && wait_n < 200);
    check("rst_vs_seen", 32'(vsync), 32'd1);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("rst_outputs", 32'({hsync, vsync, de, ma, ra, frame_start}), 32'd0);
    reset_n = 1'b1;
    tick();
    check("rst_fs", 32'(frame_start), 32'd1);
    check("rst_ma0", 32'(ma), 32'h100);
    check("rst_vs_off", 32'(vsync), 32'd0);
    tick();
    check("rst_ma1", 32'(ma), 32'h101);

    // ---- degenerate geometry: every ce is a frame ----
    set_cfg(0, 1, 0, 1, 0, 1, 0, 1, 0, 'h2A);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("degen_fs_%0d", k), 32'(frame_start), 32'd1);
      if (k == 2) begin
        check("degen_de", 32'(de), 32'd1);
        check("degen_ma", 32'(ma), 32'h2A);
        check("degen_vs", 32'(vsync), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
